// File: rtl/rc4_seq_controller.sv
// Phase sequencer for the RC4 keystream datapath: S-load, K-load, KSA, PRGA and readout.
// Datapath-facing outputs only move on divider ticks so they are stable across a whole datapath step.
module rc4_seq_controller #(
  parameter int unsigned DIV     = 2,
  parameter int unsigned KSA_MAX = 32,
  parameter int unsigned OUT_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       eqz3,
  input  logic       eqz4,
  input  logic       eqz5,
  input  logic       rd_req,
  output logic       clk_rst,
  output logic       en_s,
  output logic       en_k,
  output logic       reset1,
  output logic       reset2,
  output logic       reset3,
  output logic       reset4,
  output logic       reset_reg,
  output logic       reset_counter_final,
  output logic       enc,
  output logic       wr_1,
  output logic       rd_1,
  output logic [3:0] add_to_read,
  output logic       busy,
  output logic       out_valid,
  output logic       done,
  output logic       err
);

  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_MAX = (KSA_MAX > OUT_LEN) ? KSA_MAX : OUT_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_S, S_LOAD_K, S_KSA, S_PRGA, S_READ, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RD_IDLE, RD_WAIT, RD_PULSE, RD_HOLD
  } rd_phase_t;

  state_t           state;
  rd_phase_t        rd_phase;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] step_cnt;
  logic             start_pend;
  logic             tick_c;
  logic             wd_expire_c;
  logic             abort_c;

  assign tick_c      = !clk_rst && (div_cnt == DIV_W'(DIV - 1));
  assign wd_expire_c = (step_cnt == CNT_W'(KSA_MAX));
  // A status flag arriving on the expiry tick takes priority over the watchdog.
  assign abort_c = tick_c && wd_expire_c &&
                   (((state == S_LOAD_S) && !reset1 && !eqz3) ||
                    ((state == S_LOAD_K) && !eqz4) ||
                    ((state == S_KSA)    && !eqz5));

  // Step divider, held cleared while the datapath divider is in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 div_cnt <= '0;
    else if (clk_rst || tick_c) div_cnt <= '0;
    else                       div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      rd_phase            <= RD_IDLE;
      step_cnt            <= '0;
      start_pend          <= 1'b0;
      clk_rst             <= 1'b1;
      reset1              <= 1'b1;
      reset2              <= 1'b1;
      reset3              <= 1'b1;
      reset4              <= 1'b1;
      reset_reg           <= 1'b1;
      reset_counter_final <= 1'b1;
      en_s                <= 1'b0;
      en_k                <= 1'b0;
      enc                 <= 1'b0;
      wr_1                <= 1'b0;
      rd_1                <= 1'b0;
      add_to_read         <= 4'd0;
      busy                <= 1'b0;
      out_valid           <= 1'b0;
      done                <= 1'b0;
      err                 <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (abort_c) begin
        state               <= S_IDLE;
        step_cnt            <= '0;
        err                 <= 1'b1;
        busy                <= 1'b0;
        clk_rst             <= 1'b1;
        reset1              <= 1'b1;
        reset2              <= 1'b1;
        reset3              <= 1'b1;
        reset4              <= 1'b1;
        reset_reg           <= 1'b1;
        reset_counter_final <= 1'b1;
        en_s                <= 1'b0;
        en_k                <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_LOAD_S;
              clk_rst  <= 1'b0;
              busy     <= 1'b1;
              err      <= 1'b0;
              done     <= 1'b0;
              step_cnt <= '0;
            end
          end
          S_LOAD_S: begin
            if (tick_c) begin
              // First step after entry releases the load counters.
              if (reset1) begin
                reset1   <= 1'b0;
                reset2   <= 1'b0;
                en_s     <= 1'b1;
                step_cnt <= step_cnt + CNT_W'(1);
              end else if (eqz3) begin
                en_s     <= 1'b0;
                en_k     <= 1'b1;
                reset1   <= 1'b1;
                state    <= S_LOAD_K;
                step_cnt <= '0;
              end else begin
                step_cnt <= step_cnt + CNT_W'(1);
              end
            end
          end
          S_LOAD_K: begin
            if (tick_c) begin
              reset1 <= 1'b0;
              if (eqz4) begin
                en_k     <= 1'b0;
                reset3   <= 1'b0;
                reset1   <= 1'b1;
                state    <= S_KSA;
                step_cnt <= '0;
              end else begin
                step_cnt <= step_cnt + CNT_W'(1);
              end
            end
          end
          S_KSA: begin
            if (tick_c) begin
              reset1 <= 1'b0;
              if (eqz5) begin
                reset4              <= 1'b0;
                reset_reg           <= 1'b0;
                reset_counter_final <= 1'b0;
                enc                 <= 1'b1;
                wr_1                <= 1'b1;
                state               <= S_PRGA;
                step_cnt            <= '0;
              end else begin
                step_cnt <= step_cnt + CNT_W'(1);
              end
            end
          end
          S_PRGA: begin
            if (tick_c) begin
              if (step_cnt == CNT_W'(OUT_LEN - 1)) begin
                enc                 <= 1'b0;
                wr_1                <= 1'b0;
                reset_counter_final <= 1'b1;
                rd_1                <= 1'b1;
                add_to_read         <= 4'd0;
                rd_phase            <= RD_IDLE;
                state               <= S_READ;
                step_cnt            <= '0;
              end else begin
                step_cnt <= step_cnt + CNT_W'(1);
              end
            end
          end
          S_READ: begin
            // One outstanding read; requests during a pending read are dropped.
            case (rd_phase)
              RD_IDLE:  if (rd_req) rd_phase <= RD_WAIT;
              RD_WAIT:  if (tick_c) rd_phase <= RD_PULSE;
              RD_PULSE: begin
                out_valid <= 1'b1;
                rd_phase  <= RD_HOLD;
              end
              RD_HOLD: begin
                if (tick_c) begin
                  if (add_to_read == 4'(OUT_LEN - 1)) begin
                    state    <= S_DONE;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    rd_1     <= 1'b0;
                    rd_phase <= RD_IDLE;
                  end else begin
                    add_to_read <= add_to_read + 4'd1;
                    rd_phase    <= rd_req ? RD_WAIT : RD_IDLE;
                  end
                end
              end
              default: rd_phase <= RD_IDLE;
            endcase
          end
          S_DONE: begin
            // Restart is held until a tick so the reset pulse spans one full step.
            if ((start || start_pend) && tick_c) begin
              start_pend          <= 1'b0;
              reset1              <= 1'b1;
              reset2              <= 1'b1;
              reset3              <= 1'b1;
              reset4              <= 1'b1;
              reset_reg           <= 1'b1;
              reset_counter_final <= 1'b1;
              done                <= 1'b0;
              err                 <= 1'b0;
              busy                <= 1'b1;
              step_cnt            <= '0;
              state               <= S_LOAD_S;
            end else if (start) begin
              start_pend <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_seq_controller.sv
// Bench for rc4_seq_controller with a small datapath flag model and a readout scoreboard.
`timescale 1ns/1ps
module tb_rc4_seq_controller;

  logic       clk = 1'b0;
  logic       reset, start, rd_req;
  logic       eqz3 = 1'b0, eqz4 = 1'b0, eqz5 = 1'b0;
  logic       clk_rst, en_s, en_k, reset1, reset2, reset3, reset4;
  logic       reset_reg, reset_counter_final, enc, wr_1, rd_1;
  logic [3:0] add_to_read;
  logic       busy, out_valid, done, err;

  int checks   = 0;
  int failures = 0;
  bit hold_eqz4_low = 1'b0;
  int cnt_s = 0, cnt_k = 0, cnt_5 = 0;
  int exp_q[$];

  rc4_seq_controller #(.DIV(2), .KSA_MAX(32), .OUT_LEN(16)) dut (
    .clk(clk), .reset(reset), .start(start), .eqz3(eqz3), .eqz4(eqz4), .eqz5(eqz5),
    .rd_req(rd_req), .clk_rst(clk_rst), .en_s(en_s), .en_k(en_k),
    .reset1(reset1), .reset2(reset2), .reset3(reset3), .reset4(reset4),
    .reset_reg(reset_reg), .reset_counter_final(reset_counter_final),
    .enc(enc), .wr_1(wr_1), .rd_1(rd_1), .add_to_read(add_to_read),
    .busy(busy), .out_valid(out_valid), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Datapath flag model: eqz3 after 8 steps of en_s, eqz4 after 16 of en_k, eqz5 after 22 of KSA.
  always @(negedge clk) begin
    cnt_s = (en_s === 1'b1) ? cnt_s + 1 : 0;
    cnt_k = (en_k === 1'b1) ? cnt_k + 1 : 0;
    cnt_5 = (reset3 === 1'b0 && reset4 === 1'b1) ? cnt_5 + 1 : 0;
    eqz3  = (cnt_s >= 16);
    eqz4  = !hold_eqz4_low && (cnt_k >= 32);
    eqz5  = (cnt_5 >= 44);
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: got time %0t expected finish before 1ms", $time);
    $fatal(1);
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_phases();
    int n;
    n = 0;
    while (en_s !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (en_s !== 1'b1) begin failures++; $display("FAIL en_s_rise: got %b expected 1", en_s); end
    n = 0;
    while (en_s === 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n !== 16) begin failures++; $display("FAIL en_s_len: got %0d expected 16 clocks", n); end
    checks++;
    if (en_k !== 1'b1) begin failures++; $display("FAIL en_k_follow: got %b expected 1", en_k); end
    n = 0;
    while (en_k === 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n !== 32) begin failures++; $display("FAIL en_k_len: got %0d expected 32 clocks", n); end
    checks++;
    if (reset3 !== 1'b0) begin failures++; $display("FAIL ksa_reset3: got %b expected 0", reset3); end
    n = 0;
    while (wr_1 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if ({enc, wr_1, reset4, reset_reg, reset_counter_final} !== 5'b11000) begin
      failures++;
      $display("FAIL prga_entry: got %b expected 11000", {enc, wr_1, reset4, reset_reg, reset_counter_final});
    end
    n = 0;
    while (wr_1 === 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n !== 32) begin failures++; $display("FAIL wr_1_len: got %0d expected 32 clocks", n); end
    checks++;
    if ({enc, rd_1, reset_counter_final, add_to_read} !== 7'b0110000) begin
      failures++;
      $display("FAIL read_entry: got %b expected 0110000", {enc, rd_1, reset_counter_final, add_to_read});
    end
  endtask

  task automatic do_reads();
    int seen, n, exp_a;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      rd_req = 1'b1;
      exp_q.push_back(i);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        rd_req = 1'b0;
        if (out_valid === 1'b1) begin
          seen++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected: got addr %0d expected no out_valid", add_to_read);
          end else begin
            exp_a = exp_q.pop_front();
            if (add_to_read !== 4'(exp_a)) begin
              failures++;
              $display("FAIL rd_addr: got %0d expected %0d", add_to_read, exp_a);
            end
          end
        end
      end
    end
    n = 0;
    while (done !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (seen !== 16 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rd_count: got %0d pulses expected 16 (left %0d)", seen, exp_q.size());
    end
    exp_q.delete();
    checks++;
    if ({done, rd_1, busy} !== 3'b100) begin
      failures++;
      $display("FAIL done_state: got %b expected 100", {done, rd_1, busy});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rd_req = 1'b0;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if ({clk_rst, reset1, reset2, reset3, reset4, reset_reg, reset_counter_final} !== 7'h7f) begin
        failures++;
        $display("FAIL reset_resets%0d: got %b expected 1111111", p,
                 {clk_rst, reset1, reset2, reset3, reset4, reset_reg, reset_counter_final});
      end
      checks++;
      if ({en_s, en_k, enc, wr_1, rd_1, add_to_read} !== 9'd0) begin
        failures++;
        $display("FAIL reset_enables%0d: got %b expected 0", p, {en_s, en_k, enc, wr_1, rd_1, add_to_read});
      end
      checks++;
      if ({busy, done, out_valid, err} !== 4'd0) begin
        failures++;
        $display("FAIL reset_status%0d: got %b expected 0000", p, {busy, done, out_valid, err});
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_full_run();
    pulse_start();
    checks++;
    if ({busy, clk_rst} !== 2'b10) begin
      failures++;
      $display("FAIL start_busy: got %b expected 10", {busy, clk_rst});
    end
    run_phases();
    do_reads();
  endtask

  task automatic test_restart_from_done();
    int n;
    pulse_start();
    n = 0;
    while (reset1 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if ({reset1, reset2, reset3, reset4, done} !== 5'b11110) begin
      failures++;
      $display("FAIL restart_pulse: got %b expected 11110", {reset1, reset2, reset3, reset4, done});
    end
    n = 0;
    while (reset1 === 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (n !== 2 || en_s !== 1'b1) begin
      failures++;
      $display("FAIL restart_len: got %0d clocks en_s=%b expected 2 clocks en_s=1", n, en_s);
    end
    run_phases();
    do_reads();
  endtask

  task automatic test_watchdog();
    int n;
    hold_eqz4_low = 1'b1;
    pulse_start();
    n = 0;
    while (en_k !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (err !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n !== 66) begin failures++; $display("FAIL wd_time: got %0d clocks expected 66", n); end
    checks++;
    if ({clk_rst, reset1, reset2, reset3, reset4, reset_reg, reset_counter_final, en_k, busy} !== 9'b111111100) begin
      failures++;
      $display("FAIL wd_state: got %b expected 111111100",
               {clk_rst, reset1, reset2, reset3, reset4, reset_reg, reset_counter_final, en_k, busy});
    end
    hold_eqz4_low = 1'b0;
    pulse_start();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL wd_err_clear: got %b expected 0", err); end
    run_phases();
    do_reads();
  endtask

  task automatic test_reset_mid_ksa();
    int n;
    pulse_start();
    n = 0;
    while (!(reset3 === 1'b0 && reset4 === 1'b1) && n < 200) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({clk_rst, reset1, reset2, reset3, reset4, reset_reg, reset_counter_final} !== 7'h7f ||
        {en_s, en_k, enc, wr_1, rd_1, busy, done, err, add_to_read} !== 12'd0) begin
      failures++;
      $display("FAIL mid_ksa_reset: got %b expected 1111111000000000000",
               {clk_rst, reset1, reset2, reset3, reset4, reset_reg, reset_counter_final,
                en_s, en_k, enc, wr_1, rd_1, busy, done, err, add_to_read});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulse_start();
    n = 0;
    while (en_s !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if ({en_s, reset1, reset2, reset3, reset4} !== 5'b10011) begin
      failures++;
      $display("FAIL clean_load_s: got %b expected 10011", {en_s, reset1, reset2, reset3, reset4});
    end
    run_phases();
    do_reads();
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_restart_from_done();
    test_watchdog();
    test_reset_mid_ksa();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc4_seq_controller.md
Name: rc4_seq_controller

Overview:
- Top-level sequencer for the RC4 keystream datapath.
- Drives the datapath's enables, phase resets, write/read strobes and keystream read address through five phases: S-load, K-load, KSA, PRGA, readout.
- Uses the datapath status flags eqz3, eqz4 and eqz5, with a watchdog on each phase.
- Runs on the system clock and owns the datapath's divider reset, so the datapath steps on every DIV-th clock.

Parameters:
- DIV, 2, system clocks per datapath step; must match the datapath clock divider.
- KSA_MAX, 32, watchdog limit in datapath steps for any single phase.
- OUT_LEN, 16, keystream nibbles produced and read per run (max 16).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle pulse; begins a run when in IDLE.
- eqz3, input, 1, datapath S-load pair counter reached 7.
- eqz4, input, 1, datapath K index reached 15.
- eqz5, input, 1, datapath KSA step counter reached 21.
- rd_req, input, 1, host request for the next keystream nibble.
- clk_rst, output, 1, datapath clock-divider reset.
- en_s, output, 1, S-array load enable.
- en_k, output, 1, K-array load enable.
- reset1, reset2, reset3, reset4, output, 1 each, datapath phase counter/register resets.
- reset_reg, output, 1, PRGA j-register reset.
- reset_counter_final, output, 1, keystream write-address counter reset.
- enc, output, 1, PRGA enable.
- wr_1, output, 1, keystream write strobe.
- rd_1, output, 1, keystream read enable.
- add_to_read, output, 4, keystream read address.
- busy, output, 1, high outside IDLE and DONE.
- out_valid, output, 1, one-cycle pulse; the datapath output is valid for the current add_to_read.
- done, output, 1, level; run complete.
- err, output, 1, sticky watchdog error.

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - All datapath resets high: clk_rst, reset1-4, reset_reg, reset_counter_final.
  - en_s, en_k, enc, wr_1, rd_1 low; add_to_read=0.
  - busy, done, out_valid, err = 0; step divider and watchdog cleared.
- Step tick: an internal divider counts 0..DIV-1; tick=1 when it is DIV-1.
  - The divider runs only while clk_rst=0.
  - All datapath-facing outputs change only on the clock edge where tick=1, so they are stable across one full datapath step.
- IDLE:
  - On start, go to LOAD_S and deassert clk_rst.
  - The first tick after that releases reset1 and reset2 and raises en_s.
  - start is ignored outside IDLE and DONE.
- LOAD_S:
  - en_s=1.
  - On the tick with eqz3=1, drop en_s, pulse reset1 for one step and go to LOAD_K.
- LOAD_K:
  - en_k=1.
  - On the tick with eqz4=1, drop en_k, release reset3 and pulse reset1 for one step (KSA counters restart) and go to KSA.
- KSA:
  - reset3 is released; the swap unit is active.
  - On the tick with eqz5=1, release reset4 and reset_reg, set enc=1 and go to PRGA.
- PRGA:
  - enc=1 and reset_counter_final released; wr_1=1 for exactly OUT_LEN steps (step counter 0..OUT_LEN-1).
  - After the last step, drop enc and wr_1, assert reset_counter_final and go to READ.
- READ:
  - rd_1=1 and add_to_read holds the next address, starting at 0.
  - On rd_req, out_valid pulses one cycle after the next tick, then add_to_read increments.
  - After address OUT_LEN-1 is served, go to DONE.
  - rd_req while a read is pending is ignored (no queueing).
- DONE:
  - done=1 and busy=0; rd_1 drops.
  - On start, all datapath resets pulse high for one step, done clears, and the controller re-enters LOAD_S.
- Watchdog:
  - Per-phase step counter, cleared on every phase change.
  - If it exceeds KSA_MAX in LOAD_S, LOAD_K or KSA: set err, assert all datapath resets, go to IDLE.
  - err clears only on reset or on the next start.
- Simultaneous events:
  - Status flag and watchdog expiry on the same tick: the flag wins.
  - Asynchronous reset mid-run forces the reset values immediately, with no partial outputs.
- add_to_read wraps 15->0 only across runs; it is never incremented past OUT_LEN-1.

Test Plan:
- Reset held 3 clocks, then released -> all datapath resets=1, en_s/en_k/enc/wr_1/rd_1=0, add_to_read=0, busy=0.
- start pulse, eqz3 after 8 steps, eqz4 after 16, eqz5 after 22 (DIV=2):
  - en_s high 16 clocks, then en_k high 32 clocks, then enc high with wr_1 high exactly 16 steps.
  - Each output transitions only on tick edges.
- In READ, issue 16 rd_req pulses spaced 4 clocks apart -> 16 out_valid pulses with add_to_read 0..15, then done=1 and rd_1=0.
- eqz4 held low in LOAD_K -> err=1 after 33 steps, state IDLE, all resets high; a following start clears err and the run completes.
- reset asserted mid-KSA -> outputs reach reset values in the same cycle; start after release begins a clean LOAD_S.
- start from DONE -> one-step reset pulse on reset1-4, done clears, en_s rises on the next tick.
